adc_front_end: RTL and testbench
================================

Name: adc_front_end

Overview:
- Upstream stage for the spread-spectrum correlators.
- Takes raw parallel ADC words, removes a programmable DC offset and optionally averages/decimates by 2^D.
- Buffers results in a small FIFO and drives the shared ADC[15:0]/PushADC sample bus read by every correlator block.
- Control and status registers sit on the same addr/Wdata/write/read/Rdata bus as the correlators.

Parameters:
- FIFO_DEPTH, 8, sample FIFO entries (power of 2, 2..16).
- BASE_ADDR, 32'hFE000010, base of the 4-register window.
- MIN_GAP, 1, minimum clk cycles between PushADC pulses (1 = back-to-back allowed).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- addr  in  32  bus address
- Wdata  in  32  bus write data
- write  in  1  bus write strobe
- read  in  1  bus read strobe
- Rdata  out  32  bus read data (combinational)
- raw_data  in  16  signed raw ADC word
- raw_valid  in  1  raw_data valid this cycle
- ADC  out  16  conditioned signed sample to correlators
- PushADC  out  1  one-cycle sample strobe to correlators

Behaviour:
- Reset and clock: rst is asynchronous, active-high; clk is the clock. On rst, all registers, FIFO pointers, accumulator, ADC, PushADC and Rdata go to 0.
- Register map (offsets from BASE_ADDR):
  - +0x0 CTRL: bit0 EN; bits[4:2] D (0..4; values 5..7 clamp to 4); bit8 CLR, write-1 pulse, reads 0.
  - +0x4 OFFSET: bits[15:0], signed.
  - +0x8 STATUS (read-only): bit0 OVF sticky, bit1 SAT sticky, bits[12:8] FIFO level.
  - +0xC COUNT: 32-bit count of PushADC pulses issued; writable.
- Read path: Rdata = selected register when read=1 and addr matches, else 0; unmapped addresses return 0.
- Conditioning pipeline:
  - S1: on raw_valid && EN, register x = sext17(raw_data) - sext17(OFFSET).
  - S2: acc (21-bit signed) += x and k increments. When k reaches 2^D-1, y = (acc + x) >>> D, saturated to [-32768, 32767]; SAT is set if clipping occurred. Then acc = 0, k = 0 and y is written to the FIFO.
  - D=0: every sample passes through.
- FIFO:
  - If full at write time, the new sample is dropped and OVF is set; stored data is untouched.
  - Simultaneous write and pop when full is allowed: the pop frees the slot and the write succeeds.
- Output:
  - A pop occurs when the FIFO is non-empty, EN=1, write=0 (correlators ignore PushADC during bus writes) and at least MIN_GAP cycles have elapsed since the last push.
  - On pop, ADC is registered with the data and PushADC=1 for exactly one cycle; COUNT increments.
  - ADC holds its last value while PushADC=0.
- Latency: D=0 with empty FIFO gives PushADC high 3 cycles after the raw_valid cycle.
- CLR: clears OVF/SAT the cycle after the write. A CLR coinciding with a new OVF/SAT event leaves the flag set.
- Control changes mid-operation:
  - EN 1->0: the accumulator, k and the FIFO are flushed; no further pushes. In-flight S1 data is discarded. COUNT and OFFSET are retained.
  - A write to CTRL changing D flushes acc/k; the FIFO is kept.
  - An OFFSET write applies to raw samples registered after the write cycle.
- COUNT wraps 0xFFFFFFFF -> 0. A bus write to COUNT in the same cycle as a push takes Wdata (the write suppresses the push anyway).

Test Plan:
- Reset, EN=1, D=0, OFFSET=0x0010, raw_valid with raw_data=0x0110 -> 3 cycles later PushADC=1 for 1 cycle, ADC=0x0100, COUNT=1.
- D=2, raw 100, 200, 300, 401 on consecutive raw_valid -> exactly one push, ADC=250 (1001>>>2), no push on the first three samples.
- OFFSET=0x7FFF, raw_data=0x8000 -> ADC=0x8000 (saturated -32768), STATUS.SAT=1; then CTRL.CLR -> SAT=0.
- Hold write=1 for 12 cycles while feeding 12 samples at D=0 -> no PushADC during writes; 8 samples stored, 4 dropped, OVF=1, STATUS level=8; after write drops, 8 back-to-back pushes in order.
- MIN_GAP=4, 3 samples queued -> pushes spaced exactly 4 cycles apart.
- Mid-stream EN=0 with 5 queued samples, then assert rst during raw_valid -> no further pushes, level=0, all outputs 0 after rst.

Source files
------------

// File: rtl/adc_front_end.sv
`default_nettype none
// ============================================================================
// Module      : adc_front_end
// Description : ADC conditioning front end for the spread-spectrum
//               correlators. Subtracts a programmable DC offset from each raw
//               ADC word, averages/decimates by 2^D, buffers the results in a
//               small FIFO and drives the shared ADC/PushADC sample bus.
//               Control/status registers sit on the correlator bus.
// Ports       : clk, rst            - clock, asynchronous active-high reset
//               addr, Wdata, write,
//               read, Rdata         - register bus (Rdata combinational)
//               raw_data, raw_valid - signed raw ADC word and its strobe
//               ADC, PushADC        - conditioned sample and one-cycle strobe
// Registers   : +0x0 CTRL   {CLR[8], D[4:2], EN[0]}
//               +0x4 OFFSET [15:0] signed
//               +0x8 STATUS {LEVEL[12:8], SAT[1], OVF[0]} read-only
//               +0xC COUNT  push counter, writable
// Revision    : 1.0 - initial release
// ============================================================================
module adc_front_end #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'hFE000010,
  parameter int          MIN_GAP    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] Wdata,
  input  logic        write,
  input  logic        read,
  output logic [31:0] Rdata,
  input  logic [15:0] raw_data,
  input  logic        raw_valid,
  output logic [15:0] ADC,
  output logic        PushADC
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam int GW = $clog2(MIN_GAP + 1);

  localparam logic [31:0]   ADDR_CTRL   = BASE_ADDR;
  localparam logic [31:0]   ADDR_OFFSET = BASE_ADDR + 32'h4;
  localparam logic [31:0]   ADDR_STATUS = BASE_ADDR + 32'h8;
  localparam logic [31:0]   ADDR_COUNT  = BASE_ADDR + 32'hC;
  localparam logic [PW-1:0] DEPTH_P     = PW'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_P       = GW'(MIN_GAP);
  localparam logic [GW-1:0] GAP_ONE     = GW'(1);

  // Control / status registers
  logic        en;
  logic [2:0]  d;
  logic [15:0] offset;
  logic        ovf;
  logic        sat;
  logic [31:0] count;

  // Pipeline state
  logic signed [16:0] x;
  logic               x_valid;
  logic signed [20:0] acc;
  logic [3:0]         k;

  // FIFO
  logic [15:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] level;
  logic [GW-1:0] gap_cnt;

  // Bus decode
  logic       ctrl_wr;
  logic       off_wr;
  logic       cnt_wr;
  logic       clr;
  logic [2:0] d_new;
  logic       flush_all;
  logic       d_change;

  assign ctrl_wr = write && (addr == ADDR_CTRL);
  assign off_wr  = write && (addr == ADDR_OFFSET);
  assign cnt_wr  = write && (addr == ADDR_COUNT);
  assign clr     = ctrl_wr && Wdata[8];
  assign d_new   = (Wdata[4:2] > 3'd4) ? 3'd4 : Wdata[4:2];

  // Disabling (or running disabled) empties the whole pipeline; a decimation
  // change only restarts the running average.
  assign flush_all = !en || (ctrl_wr && !Wdata[0]);
  assign d_change  = ctrl_wr && (d_new != d);

  // Averaging stage: the final sample of a block is added combinationally so
  // the result reaches the FIFO in the same cycle it arrives.
  logic signed [20:0] x_ext;
  logic signed [20:0] sum;
  logic signed [20:0] shifted;
  logic [3:0]         k_last;
  logic               clip_hi;
  logic               clip_lo;
  logic [15:0]        y;

  assign x_ext   = {{4{x[16]}}, x};
  assign sum     = acc + x_ext;
  assign shifted = sum >>> d;
  assign k_last  = 4'((5'd1 << d) - 5'd1);
  assign clip_hi = shifted > 21'sd32767;
  assign clip_lo = shifted < -21'sd32768;
  assign y       = clip_hi ? 16'h7FFF : (clip_lo ? 16'h8000 : shifted[15:0]);

  logic fifo_try;
  logic full;
  logic gap_ok;
  logic pop;
  logic fifo_wr;
  logic ovf_evt;
  logic sat_evt;

  assign fifo_try = x_valid && !flush_all && !d_change && (k == k_last);
  assign level    = wptr - rptr;
  assign full     = (level == DEPTH_P);
  assign gap_ok   = (gap_cnt >= GAP_P);
  // Correlators ignore PushADC during any bus write, so no pop then.
  assign pop      = (level != '0) && en && !write && gap_ok;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign fifo_wr  = fifo_try && (!full || pop);
  assign ovf_evt  = fifo_try && full && !pop;
  assign sat_evt  = fifo_try && (clip_hi || clip_lo);

  // Read mux
  always_comb begin
    Rdata = 32'h0;
    if (!rst && read) begin
      case (addr)
        ADDR_CTRL:   Rdata = {27'h0, d, 1'b0, en};
        ADDR_OFFSET: Rdata = {16'h0, offset};
        ADDR_STATUS: Rdata = {19'h0, 5'(level), 6'h0, sat, ovf};
        ADDR_COUNT:  Rdata = count;
        default:     Rdata = 32'h0;
      endcase
    end
  end

  // FIFO storage carries no reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem[wptr[AW-1:0]] <= y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en      <= 1'b0;
      d       <= 3'd0;
      offset  <= 16'h0;
      ovf     <= 1'b0;
      sat     <= 1'b0;
      count   <= 32'h0;
      x       <= '0;
      x_valid <= 1'b0;
      acc     <= '0;
      k       <= 4'd0;
      wptr    <= '0;
      rptr    <= '0;
      gap_cnt <= GAP_P;
      ADC     <= 16'h0;
      PushADC <= 1'b0;
    end else begin
      // Registers
      if (ctrl_wr) begin
        en <= Wdata[0];
        d  <= d_new;
      end
      if (off_wr) begin
        offset <= Wdata[15:0];
      end
      // A fresh event in the CLR cycle wins over the clear.
      ovf <= (ovf && !clr) || ovf_evt;
      sat <= (sat && !clr) || sat_evt;

      // Offset removal
      x_valid <= raw_valid && !flush_all;
      x       <= $signed({raw_data[15], raw_data}) - $signed({offset[15], offset});

      // Accumulator
      if (flush_all || d_change) begin
        acc <= '0;
        k   <= 4'd0;
      end else if (x_valid) begin
        if (k == k_last) begin
          acc <= '0;
          k   <= 4'd0;
        end else begin
          acc <= sum;
          k   <= k + 4'd1;
        end
      end

      // FIFO pointers
      if (flush_all) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (fifo_wr) begin
          wptr <= wptr + PW'(1);
        end
        if (pop) begin
          rptr <= rptr + PW'(1);
        end
      end

      // Output strobe and spacing
      PushADC <= pop;
      if (pop) begin
        ADC     <= mem[rptr[AW-1:0]];
        gap_cnt <= GAP_ONE;
      end else if (!gap_ok) begin
        gap_cnt <= gap_cnt + GAP_ONE;
      end

      if (cnt_wr) begin
        count <= Wdata;
      end else if (pop) begin
        count <= count + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_front_end.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_front_end
// Description : Self-checking bench for adc_front_end. A queue-based model
//               of the sample path is compared against the DUT every cycle;
//               directed scenarios pin the model with literal expectations.
//               A second instance with MIN_GAP=4 checks push spacing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_front_end;

  localparam logic [31:0] BASE  = 32'hFE000010;
  localparam int          DEPTH = 8;
  localparam longint      MG    = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] Wdata = 32'h0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [15:0] raw_data = 16'h0;
  logic        raw_valid = 1'b0;
  logic [31:0] Rdata;
  logic [15:0] ADC;
  logic        PushADC;
  logic [31:0] g_Rdata;
  logic [15:0] g_ADC;
  logic        g_Push;

  adc_front_end #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE), .MIN_GAP(1)) dut (
    .clk(clk), .rst(rst), .addr(addr), .Wdata(Wdata), .write(write),
    .read(read), .Rdata(Rdata), .raw_data(raw_data), .raw_valid(raw_valid),
    .ADC(ADC), .PushADC(PushADC)
  );

  adc_front_end #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE), .MIN_GAP(4)) dut_gap (
    .clk(clk), .rst(rst), .addr(addr), .Wdata(Wdata), .write(write),
    .read(read), .Rdata(g_Rdata), .raw_data(raw_data), .raw_valid(raw_valid),
    .ADC(g_ADC), .PushADC(g_Push)
  );

  always #5 clk = ~clk;

  int tb_cyc = 0;
  always @(posedge clk) tb_cyc++;

  int n_vec = 0;
  int n_err = 0;
  int push_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_en = 0;
  int          m_d = 0;
  int          m_off = 0;
  bit          m_ovf = 0;
  bit          m_sat = 0;
  logic [31:0] m_count = 0;
  int          m_q[$];
  bit          m_s1v = 0;
  int          m_s1x = 0;
  int          m_sum = 0;
  int          m_n = 0;
  bit          m_push = 0;
  logic [15:0] m_adc = 0;
  longint      cyc = 0;
  longint      last_push = -100;

  task automatic model_reset();
    m_en = 0; m_d = 0; m_off = 0; m_ovf = 0; m_sat = 0; m_count = 0;
    m_q.delete(); m_s1v = 0; m_s1x = 0; m_sum = 0; m_n = 0;
    m_push = 0; m_adc = 0; last_push = -100;
  endtask

  task automatic model_step();
    bit cw, ow, kw, flush, dchg, pop, clr, novf, nsat;
    int dn, y;
    cw = write && addr == BASE;
    ow = write && addr == BASE + 32'h4;
    kw = write && addr == BASE + 32'hC;
    dn = int'(Wdata[4:2]);
    if (dn > 4) dn = 4;
    flush = !m_en || (cw && !Wdata[0]);
    dchg  = cw && (dn != m_d);
    pop   = (m_q.size() > 0) && m_en && !write && (cyc - last_push >= MG);
    novf = 0; nsat = 0;
    m_push = pop;
    if (pop) begin
      m_adc = 16'(m_q.pop_front());
      last_push = cyc;
    end
    if (flush) begin
      m_q.delete(); m_sum = 0; m_n = 0;
    end else if (dchg) begin
      m_sum = 0; m_n = 0;
    end else if (m_s1v) begin
      m_sum += m_s1x;
      m_n++;
      if (m_n == (1 << m_d)) begin
        y = m_sum >>> m_d;
        if (y > 32767) begin y = 32767; nsat = 1; end
        else if (y < -32768) begin y = -32768; nsat = 1; end
        if (m_q.size() < DEPTH) m_q.push_back(y);
        else novf = 1;
        m_sum = 0; m_n = 0;
      end
    end
    m_s1v = raw_valid && !flush;
    m_s1x = int'($signed(raw_data)) - m_off;
    clr = cw && Wdata[8];
    m_ovf = (m_ovf && !clr) || novf;
    m_sat = (m_sat && !clr) || nsat;
    m_count = kw ? Wdata : m_count + 32'(pop);
    if (ow) m_off = int'($signed(Wdata[15:0]));
    if (cw) begin m_en = Wdata[0]; m_d = dn; end
    cyc++;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  function automatic logic [31:0] exp_rdata();
    if (rst || !read) return 32'h0;
    case (addr)
      BASE:          return (32'(m_d) << 2) | 32'(m_en);
      BASE + 32'h4:  return {16'h0, 16'(m_off)};
      BASE + 32'h8:  return (32'(m_q.size()) << 8) | (32'(m_sat) << 1) | 32'(m_ovf);
      BASE + 32'hC:  return m_count;
      default:       return 32'h0;
    endcase
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("PushADC", 32'(PushADC), 32'(m_push));
    chk("ADC", 32'(ADC), 32'(m_adc));
    chk("Rdata", Rdata, exp_rdata());
    if (PushADC) push_seen++;
  end

  // Push log of the MIN_GAP=4 instance
  int          g_cyc[$];
  logic [15:0] g_val[$];
  always @(negedge clk) begin
    if (g_Push) begin
      g_cyc.push_back(tb_cyc);
      g_val.push_back(g_ADC);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] dat);
    addr = a; Wdata = dat; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    read = 1'b1; addr = a;
    @(negedge clk); #1;
    chk(name, Rdata, exp);
    @(posedge clk); #2;
    read = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int p0;
    int cs;
    int burst;
    int r;
    logic [15:0] v2[4];
    v2[0] = 16'd100; v2[1] = 16'd200; v2[2] = 16'd300; v2[3] = 16'd401;

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Reset state
    chk("rst_adc", 32'(ADC), 32'h0);
    rd_chk("rst_ctrl", BASE, 32'h0);
    rd_chk("rst_offset", BASE + 32'h4, 32'h0);
    rd_chk("rst_status", BASE + 32'h8, 32'h0);
    rd_chk("rst_count", BASE + 32'hC, 32'h0);

    // 1: D=0 pass-through, 3-cycle latency
    bus_write(BASE + 32'h4, 32'h0010);
    bus_write(BASE, 32'h1);
    raw_data = 16'h0110; raw_valid = 1'b1;
    tick();
    raw_valid = 1'b0;
    tick(); tick();
    @(negedge clk); #1;
    chk("t1_push", 32'(PushADC), 32'h1);
    chk("t1_adc", 32'(ADC), 32'h0100);
    @(negedge clk); #1;
    chk("t1_push_one_cycle", 32'(PushADC), 32'h0);
    tick();
    rd_chk("t1_count", BASE + 32'hC, 32'h1);

    // 2: D=2 averaging
    bus_write(BASE + 32'h4, 32'h0);
    bus_write(BASE, 32'h1 | (32'd2 << 2));
    p0 = push_seen;
    for (int i = 0; i < 4; i++) begin
      raw_data = v2[i]; raw_valid = 1'b1;
      tick();
    end
    raw_valid = 1'b0;
    tick(); tick();
    @(negedge clk); #1;
    chk("t2_push", 32'(PushADC), 32'h1);
    chk("t2_adc", 32'(ADC), 32'd250);
    repeat (4) tick();
    chk("t2_npush", 32'(push_seen - p0), 32'h1);

    // 3: saturation and CLR
    bus_write(BASE, 32'h1);
    bus_write(BASE + 32'h4, 32'h7FFF);
    raw_data = 16'h8000; raw_valid = 1'b1;
    tick();
    raw_valid = 1'b0;
    repeat (4) tick();
    chk("t3_adc", 32'(ADC), 32'h8000);
    rd_chk("t3_status_sat", BASE + 32'h8, 32'h2);
    bus_write(BASE, 32'h101);
    rd_chk("t3_status_clr", BASE + 32'h8, 32'h0);

    // 4: writes block pushes, FIFO overflow, then back-to-back drain
    bus_write(BASE + 32'h4, 32'h0);
    p0 = push_seen;
    addr = BASE + 32'h8; Wdata = 32'h0; write = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      raw_data = 16'(i); raw_valid = 1'b1;
      tick();
    end
    raw_valid = 1'b0;
    tick(); tick();
    read = 1'b1;
    @(negedge clk); #1;
    chk("t4_status", Rdata, 32'h801);
    chk("t4_nopush", 32'(push_seen - p0), 32'h0);
    @(posedge clk); #2;
    read = 1'b0; write = 1'b0;
    tick();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk); #1;
      chk("t4_drain_push", 32'(PushADC), 32'h1);
      chk("t4_drain_adc", 32'(ADC), 32'(i));
      tick();
    end
    rd_chk("t4_empty", BASE + 32'h8, 32'h1);
    bus_write(BASE, 32'h101);

    // 5: MIN_GAP=4 spacing (second instance)
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    bus_write(BASE, 32'h1);
    g_cyc.delete(); g_val.delete();
    cs = tb_cyc;
    for (int i = 0; i < 3; i++) begin
      raw_data = 16'(32'h21 + i); raw_valid = 1'b1;
      tick();
    end
    raw_valid = 1'b0;
    repeat (16) tick();
    chk("t5_gap_npush", 32'(g_cyc.size()), 32'd3);
    if (g_cyc.size() == 3) begin
      chk("t5_gap_first", 32'(g_cyc[0] - cs), 32'd3);
      chk("t5_gap_sp1", 32'(g_cyc[1] - g_cyc[0]), 32'd4);
      chk("t5_gap_sp2", 32'(g_cyc[2] - g_cyc[1]), 32'd4);
      chk("t5_gap_v0", 32'(g_val[0]), 32'h21);
      chk("t5_gap_v2", 32'(g_val[2]), 32'h23);
    end
    rd_chk("t5_count", BASE + 32'hC, 32'd3);

    // 6: EN=0 flush with queued samples, then reset during raw_valid
    addr = BASE + 32'h8; Wdata = 32'h0; write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      raw_data = 16'(32'h31 + i); raw_valid = 1'b1;
      tick();
    end
    raw_valid = 1'b0;
    tick(); tick();
    p0 = push_seen;
    bus_write(BASE, 32'h100);
    repeat (8) tick();
    chk("t6_nopush", 32'(push_seen - p0), 32'h0);
    rd_chk("t6_status", BASE + 32'h8, 32'h0);
    rd_chk("t6_count_kept", BASE + 32'hC, 32'd3);
    bus_write(BASE, 32'h1);
    raw_data = 16'h0005; raw_valid = 1'b1;
    read = 1'b1; addr = BASE + 32'hC;
    #1 rst = 1'b1;
    @(negedge clk); #1;
    chk("t6_rst_adc", 32'(ADC), 32'h0);
    chk("t6_rst_push", 32'(PushADC), 32'h0);
    chk("t6_rst_rdata", Rdata, 32'h0);
    tick();
    raw_valid = 1'b0; read = 1'b0;
    rst = 1'b0;
    rd_chk("t6_count_rst", BASE + 32'hC, 32'h0);
    rd_chk("t6_ctrl_rst", BASE, 32'h0);
    p0 = push_seen;
    repeat (5) tick();
    chk("t6_no_push_after_rst", 32'(push_seen - p0), 32'h0);

    // Randomized phase checked by the model
    bus_write(BASE, 32'h1);
    burst = 0;
    for (int n = 0; n < 3000; n++) begin
      raw_valid = ($urandom % 3) != 0;
      r = int'($urandom % 8);
      raw_data = (r == 0) ? 16'h7FFF : (r == 1) ? 16'h8000 : 16'($urandom);
      read = 1'($urandom % 2);
      addr = BASE + 32'(4 * ($urandom % 5));
      write = 1'b0;
      if (burst > 0) begin
        write = 1'b1; addr = BASE + 32'h10; Wdata = $urandom;
        burst--;
      end else if ($urandom % 200 == 0) begin
        burst = 12;
      end else if ($urandom % 12 == 0) begin
        write = 1'b1;
        case ($urandom % 5)
          0: begin
            addr = BASE;
            Wdata = {23'h0, 1'($urandom % 2), 3'h0, 3'($urandom % 8), 1'b0,
                     1'(($urandom % 16) != 0)};
          end
          1: begin
            addr = BASE + 32'h4;
            Wdata = ($urandom % 2) ? $urandom : ($urandom % 64);
          end
          2: begin
            addr = BASE + 32'hC;
            Wdata = ($urandom % 2) ? 32'hFFFFFFFE : $urandom;
          end
          3: begin addr = BASE + 32'h8; Wdata = $urandom; end
          default: begin addr = BASE + 32'h10; Wdata = $urandom; end
        endcase
      end
      tick();
    end
    write = 1'b0; read = 1'b0; raw_valid = 1'b0;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
